// File: rtl/clock_time_set_if.sv
// Key, live-counter and preset/blink signals exchanged between the time-setting
// controller (slave side) and its environment (master side).
interface clock_time_set_if;
  logic       key_set;
  logic       key_inc;
  logic       key_dec;
  logic [7:0] cur_hour;
  logic [7:0] cur_min;
  logic [7:0] cur_sec;
  logic       adjust;
  logic       PE;
  logic [7:0] pre_hour;
  logic [7:0] pre_min;
  logic [7:0] pre_sec;
  logic [2:0] blink;

  modport slave (
    input  key_set, key_inc, key_dec, cur_hour, cur_min, cur_sec,
    output adjust, PE, pre_hour, pre_min, pre_sec, blink
  );

  modport master (
    output key_set, key_inc, key_dec, cur_hour, cur_min, cur_sec,
    input  adjust, PE, pre_hour, pre_min, pre_sec, blink
  );
endinterface

// File: rtl/clock_time_set_ctrl.sv
// Time-setting controller: freezes the clock counters, edits hour/min/sec with
// inc/dec keys (with auto-repeat), then loads the presets with a one-cycle PE.
module clock_time_set_ctrl #(
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100,
  parameter int BLINK_HALF  = 250,
  parameter int TIMEOUT     = 30000
) (
  input  logic              CP,
  input  logic              _CR,
  clock_time_set_if.slave   bus
);

  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int BLK_W   = $clog2(BLINK_HALF + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MS_MAX   = 8'd59;

  typedef enum logic [2:0] {
    ST_RUN, ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC, ST_LOAD
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_set_s, r_inc_s, r_dec_s;
  logic                r_set_q, r_inc_q, r_dec_q;
  logic [7:0]          r_pre_hour, r_pre_min, r_pre_sec;
  logic [7:0]          w_hour_nxt, w_min_nxt, w_sec_nxt;
  logic                r_adjust, r_pe;
  logic [2:0]          r_blink, w_blink_nxt;
  logic [BLK_W-1:0]    r_blk_cnt, w_blk_cnt_nxt;
  logic [IDLE_W-1:0]   r_idle, w_idle_nxt;
  logic                r_rep_act, r_rep_dec, r_rep_ph;
  logic                w_rep_act_nxt, w_rep_dec_nxt, w_rep_ph_nxt;
  logic [REP_W-1:0]    r_rep_cnt, w_rep_cnt_nxt, w_rep_lim;
  logic                w_set_p, w_inc_p, w_dec_p, w_rep_held;
  logic                w_activity, w_step, w_up, w_in_set;
  logic [2:0]          w_mask;

  function automatic logic [7:0] f_step(input logic [7:0] v, input logic [7:0] vmax,
                                        input logic up);
    if (up) return (v >= vmax) ? 8'd0 : v + 8'd1;
    return (v == 8'd0) ? vmax : v - 8'd1;
  endfunction

  function automatic logic [7:0] f_clip(input logic [7:0] v, input logic [7:0] vmax);
    return (v > vmax) ? 8'd0 : v;
  endfunction

  assign w_set_p    = r_set_s & ~r_set_q;
  assign w_inc_p    = r_inc_s & ~r_inc_q;
  assign w_dec_p    = r_dec_s & ~r_dec_q;
  assign w_rep_held = r_rep_act & (r_rep_dec ? r_dec_s : r_inc_s);
  assign w_rep_lim  = r_rep_ph ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DLY - 1);
  assign w_in_set   = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN) ||
                      (r_state == ST_SET_SEC);
  assign w_mask     = (r_state == ST_SET_HOUR) ? 3'b100 :
                      (r_state == ST_SET_MIN)  ? 3'b010 :
                      (r_state == ST_SET_SEC)  ? 3'b001 : 3'b000;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt   = r_state;
    w_hour_nxt    = r_pre_hour;
    w_min_nxt     = r_pre_min;
    w_sec_nxt     = r_pre_sec;
    w_blink_nxt   = r_blink;
    w_blk_cnt_nxt = r_blk_cnt;
    w_idle_nxt    = r_idle;
    w_rep_act_nxt = r_rep_act;
    w_rep_dec_nxt = r_rep_dec;
    w_rep_ph_nxt  = r_rep_ph;
    w_rep_cnt_nxt = r_rep_cnt;
    w_activity    = 1'b0;
    w_step        = 1'b0;
    w_up          = 1'b0;

    unique case (r_state)
      ST_RUN: begin
        if (w_set_p) begin
          w_hour_nxt  = f_clip(bus.cur_hour, HOUR_MAX);
          w_min_nxt   = f_clip(bus.cur_min, MS_MAX);
          w_sec_nxt   = f_clip(bus.cur_sec, MS_MAX);
          w_state_nxt = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
        // Set beats inc/dec in the same cycle; simultaneous inc+dec cancels out.
        if (w_set_p) begin
          w_activity  = 1'b1;
          w_state_nxt = (r_state == ST_SET_HOUR) ? ST_SET_MIN :
                        (r_state == ST_SET_MIN)  ? ST_SET_SEC : ST_LOAD;
        end else if (w_inc_p || w_dec_p) begin
          w_activity = 1'b1;
          if (w_inc_p && w_dec_p) begin
            w_rep_act_nxt = 1'b0;
          end else begin
            w_step        = 1'b1;
            w_up          = w_inc_p;
            w_rep_act_nxt = 1'b1;
            w_rep_dec_nxt = w_dec_p;
            w_rep_ph_nxt  = 1'b0;
            w_rep_cnt_nxt = '0;
          end
        end else if (w_rep_held) begin
          if (r_rep_cnt == w_rep_lim) begin
            w_activity    = 1'b1;
            w_step        = 1'b1;
            w_up          = ~r_rep_dec;
            w_rep_ph_nxt  = 1'b1;
            w_rep_cnt_nxt = '0;
          end else begin
            w_rep_cnt_nxt = r_rep_cnt + REP_W'(1);
          end
        end else begin
          w_rep_act_nxt = 1'b0;
          w_rep_ph_nxt  = 1'b0;
          w_rep_cnt_nxt = '0;
        end

        if (w_activity)                          w_idle_nxt  = '0;
        else if (r_idle == IDLE_W'(TIMEOUT - 1)) w_state_nxt = ST_RUN;
        else                                     w_idle_nxt  = r_idle + IDLE_W'(1);
      end
      ST_LOAD: w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase

    if (w_step) begin
      case (r_state)
        ST_SET_HOUR: w_hour_nxt = f_step(r_pre_hour, HOUR_MAX, w_up);
        ST_SET_MIN:  w_min_nxt  = f_step(r_pre_min, MS_MAX, w_up);
        ST_SET_SEC:  w_sec_nxt  = f_step(r_pre_sec, MS_MAX, w_up);
        default: ;
      endcase
    end

    // Any state change restarts blink, idle and repeat tracking from scratch.
    if (w_state_nxt != r_state) begin
      w_blink_nxt   = 3'b000;
      w_blk_cnt_nxt = '0;
      w_idle_nxt    = '0;
      w_rep_act_nxt = 1'b0;
      w_rep_ph_nxt  = 1'b0;
      w_rep_cnt_nxt = '0;
    end else if (w_in_set) begin
      if (r_blk_cnt == BLK_W'(BLINK_HALF - 1)) begin
        w_blk_cnt_nxt = '0;
        w_blink_nxt   = r_blink ^ w_mask;
      end else begin
        w_blk_cnt_nxt = r_blk_cnt + BLK_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers see
  // pre-edge values; every register here is reset, including the key samplers.
  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      r_state    <= ST_RUN;
      r_set_s    <= 1'b1;
      r_inc_s    <= 1'b1;
      r_dec_s    <= 1'b1;
      r_set_q    <= 1'b1;
      r_inc_q    <= 1'b1;
      r_dec_q    <= 1'b1;
      r_pre_hour <= 8'd0;
      r_pre_min  <= 8'd0;
      r_pre_sec  <= 8'd0;
      r_adjust   <= 1'b0;
      r_pe       <= 1'b0;
      r_blink    <= 3'b000;
      r_blk_cnt  <= '0;
      r_idle     <= '0;
      r_rep_act  <= 1'b0;
      r_rep_dec  <= 1'b0;
      r_rep_ph   <= 1'b0;
      r_rep_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_set_s    <= bus.key_set;
      r_inc_s    <= bus.key_inc;
      r_dec_s    <= bus.key_dec;
      r_set_q    <= r_set_s;
      r_inc_q    <= r_inc_s;
      r_dec_q    <= r_dec_s;
      r_pre_hour <= w_hour_nxt;
      r_pre_min  <= w_min_nxt;
      r_pre_sec  <= w_sec_nxt;
      r_adjust   <= (w_state_nxt != ST_RUN);
      r_pe       <= (w_state_nxt == ST_LOAD);
      r_blink    <= w_blink_nxt;
      r_blk_cnt  <= w_blk_cnt_nxt;
      r_idle     <= w_idle_nxt;
      r_rep_act  <= w_rep_act_nxt;
      r_rep_dec  <= w_rep_dec_nxt;
      r_rep_ph   <= w_rep_ph_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
    end
  end

  assign bus.adjust   = r_adjust;
  assign bus.PE       = r_pe;
  assign bus.pre_hour = r_pre_hour;
  assign bus.pre_min  = r_pre_min;
  assign bus.pre_sec  = r_pre_sec;
  assign bus.blink    = r_blink;

endmodule

// File: doc/clock_time_set_ctrl.md
# clock_time_set_ctrl

Button-driven time-setting controller for the digital clock. It freezes the hour, minute and second counters and lets the user edit each field with increment and decrement keys. It then loads the edited values into the counters with a single load pulse. It sits between the debounced key inputs and the three counters' adjust/PE/preset inputs, and supplies a per-field blink mask to the display driver.

## Interface
Parameters:
- REPEAT_DLY, 500: CP cycles a key must stay held before auto-repeat starts.
- REPEAT_RATE, 100: CP cycles between auto-repeat steps.
- BLINK_HALF, 250: CP cycles per half-period of the edit-field blink.
- TIMEOUT, 30000: CP cycles with no key press in a set state before the edit is abandoned.

Ports:
- CP  in  1  system clock (1 kHz scan clock); all logic rising-edge.
- _CR  in  1  reset, asynchronous, active-low.
- key_set  in  1  debounced set key, active-high level.
- key_inc  in  1  debounced increment key, active-high level.
- key_dec  in  1  debounced decrement key, active-high level.
- cur_hour, cur_min, cur_sec  in  8 each  live counter values, binary.
- adjust  out  1  high while setting; freezes the counters.
- PE  out  1  one-cycle load pulse to all three counters.
- pre_hour, pre_min, pre_sec  out  8 each  preset values, binary.
- blink  out  3  {hour,min,sec} blank mask; 1 means blank that field.

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, LOAD.
- Key presses are rising edges of the sampled key level. Previous-level registers reset to 1, so a key held through reset release is not a press.
- RUN + key_set press:
  - Capture cur_* into pre_*. Any captured value above its maximum (hour >23, min/sec >59) becomes 0.
  - Go to SET_HOUR and assert adjust.
- Set-state progression on key_set press: SET_HOUR -> SET_MIN -> SET_SEC -> LOAD -> RUN, with LOAD lasting exactly one cycle.
- Editing in a set state: a key_inc press adds 1 to the active field and a key_dec press subtracts 1.
  - Hour wraps 23->0 and 0->23.
  - Min/sec wrap 59->0 and 0->59.
  - Inactive fields are unchanged.
- Auto-repeat: while the same key stays high, an extra step occurs REPEAT_DLY cycles after the press, then every REPEAT_RATE cycles. Releasing the key clears the repeat counter.
- Simultaneous events:
  - key_inc and key_dec pressed in the same cycle: no change.
  - key_set pressed together with inc/dec: set wins and the field is unchanged.
  - A held inc/dec repeat stops at a state change.
- Timeout: TIMEOUT consecutive cycles in a set state with no press of any key (auto-repeat steps count as activity).
  - Go to RUN with no PE.
  - adjust drops and pre_* hold their last values.
- Blink:
  - In a set state, only the active field's blink bit toggles, every BLINK_HALF cycles.
  - On entry to each set state the bit starts at 0 and the blink counter clears.
  - In RUN and LOAD, blink = 000.
- Reset (_CR low, any time including mid-edit):
  - State RUN; adjust = 0, PE = 0, pre_* = 0, blink = 000.
  - All internal counters cleared.

## Timing
- All outputs are registered.
- A key edge sampled at CP edge n takes effect (state/field update) at edge n+1.
- LOAD: PE = 1 for exactly one cycle. pre_* are stable from at least one cycle before PE rises until the next edit.
- adjust stays 1 during the LOAD cycle and falls at the same edge PE falls. The counters therefore resume one cycle after the load.
- adjust rises at the same edge the state leaves RUN.
- Auto-repeat first step occurs at press cycle + REPEAT_DLY, then every REPEAT_RATE cycles; each step causes ±1 exactly once.
- Timeout exit occurs at the edge where the idle counter reaches TIMEOUT.

## Test plan
- Reset, then cur = 10:20:30; press set -> adjust = 1, pre = 10:20:30, blink = 100 toggling every 250 cycles. Press set 3 more times -> PE pulses 1 cycle, pre = 10:20:30, adjust = 0 one cycle later.
- In SET_HOUR at 23, press inc -> 0; press dec -> 23. In SET_MIN at 0, press dec -> 59. In SET_SEC at 59, press inc -> 0.
- Hold key_inc for 800 cycles in SET_MIN starting at 5: steps at press, +500, +600, +700 -> final 9. Pressing inc and dec in the same cycle -> no change.
- Enter SET_HOUR, then go idle for 30000 cycles -> state RUN, adjust = 0, PE never asserted.
- Pull _CR low mid-edit in SET_SEC -> adjust, PE and blink go 0 immediately and pre = 0. With key_set held through reset release -> no entry to SET_HOUR until release and re-press.
- Capture cur_sec = 60 -> pre_sec = 0.
